// File: rtl/puf_response_collector.sv
// PUF response collector: synchronises two ring oscillators, counts their edges
// inside the measurement window and turns each count comparison into one key bit.
module puf_response_collector #(
    parameter int CNT_W    = 16,
    parameter int KEY_BITS = 64,
    parameter int SEL_W    = $clog2(KEY_BITS),
    parameter int BC_W     = $clog2(KEY_BITS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ro_a,
    input  logic                ro_b,
    input  logic                start_count,
    input  logic                done,
    input  logic                restart,
    output logic [SEL_W-1:0]    challenge,
    output logic [KEY_BITS-1:0] key,
    output logic [BC_W-1:0]     bit_count,
    output logic                key_valid,
    output logic                tie_seen
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [BC_W-1:0]  BC_ONE  = {{(BC_W-1){1'b0}}, 1'b1};
    localparam logic [SEL_W-1:0] SEL_ONE = {{(SEL_W-1){1'b0}}, 1'b1};
    localparam logic [BC_W-1:0]  KEY_MAX = BC_W'(KEY_BITS);

    logic [2:0]       sync_a;
    logic [2:0]       sync_b;
    logic             edge_a;
    logic             edge_b;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic             capture;
    logic             resp_bit;
    logic             tie;
    logic [BC_W-1:0]  bit_count_nxt;

    // Bit 0/1 are the metastability stages, bit 2 is history for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[1:0], ro_a};
            sync_b <= {sync_b[1:0], ro_b};
        end
    end

    assign edge_a = sync_a[1] & ~sync_a[2];
    assign edge_b = sync_b[1] & ~sync_b[2];

    assign capture       = done & ~restart;
    assign resp_bit      = cnt_a > cnt_b;
    assign tie           = cnt_a == cnt_b;
    assign bit_count_nxt = bit_count + BC_ONE;

    // A capture or restart clears the counters ahead of any same-cycle edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (restart || done) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (start_count) begin
            if (edge_a && cnt_a != CNT_MAX) begin
                cnt_a <= cnt_a + CNT_ONE;
            end
            if (edge_b && cnt_b != CNT_MAX) begin
                cnt_b <= cnt_b + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key       <= '0;
            bit_count <= '0;
            challenge <= '0;
            key_valid <= 1'b0;
            tie_seen  <= 1'b0;
        end else if (restart) begin
            key       <= '0;
            bit_count <= '0;
            challenge <= '0;
            key_valid <= 1'b0;
            tie_seen  <= 1'b0;
        end else if (capture && !key_valid) begin
            key       <= {key[KEY_BITS-2:0], resp_bit};
            bit_count <= bit_count_nxt;
            challenge <= challenge + SEL_ONE;
            if (tie) begin
                tie_seen <= 1'b1;
            end
            if (bit_count_nxt == KEY_MAX) begin
                key_valid <= 1'b1;
            end
        end
    end

endmodule

// File: doc/puf_response_collector.md
# puf_response_collector

Downstream consumer of the PUF key-extraction sequencer's `enable_ro` / `start_count` / `done` strobes. Synchronises and edge-counts a pair of ring-oscillator outputs while `start_count` is high, and on each `done` pulse turns the count comparison into one response bit. Bits are shifted into a key register and the challenge index advances. After `KEY_BITS` comparisons the key is presented with `key_valid`.

## Interface
Parameters:
- `CNT_W`, 16, width of each RO edge counter (saturating)
- `KEY_BITS`, 64, number of response bits collected into `key`; ≥2
- `SEL_W`, `$clog2(KEY_BITS)`, width of `challenge`
- `BC_W`, `$clog2(KEY_BITS+1)`, width of `bit_count`

Ports:
- `clk`  in  1  single system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `ro_a`  in  1  ring-oscillator A output, asynchronous to `clk`
- `ro_b`  in  1  ring-oscillator B output, asynchronous to `clk`
- `start_count`  in  1  level; counting window from the sequencer
- `done`  in  1  1-cycle pulse; end of measurement, capture one bit
- `restart`  in  1  1-cycle sync pulse; discard key and begin a new extraction
- `challenge`  out  SEL_W  RO-pair select for the current measurement
- `key`  out  KEY_BITS  collected response, first bit ends up at MSB
- `bit_count`  out  BC_W  bits captured so far, 0..KEY_BITS
- `key_valid`  out  1  high once KEY_BITS bits captured; sticky until `restart`/`rst`
- `tie_seen`  out  1  sticky; set if any capture saw `cnt_a == cnt_b`

## Operation
Synchroniser and edge detect, per RO:
- Two flops, then a third flop for history.
- Rising edge when `s2 & ~s3`.

Counters `cnt_a` / `cnt_b`:
- Increment by 1 on a detected edge while `start_count==1`.
- Saturate at `2^CNT_W-1`.
- Hold when `start_count==0`.

Capture on `done==1` with `restart==0`:
- If `key_valid==0`:
  - Compute `bit = (cnt_a > cnt_b)`, unsigned compare; a tie gives 0 and sets `tie_seen`.
  - `key <= {key[KEY_BITS-2:0], bit}`.
  - `bit_count` += 1.
  - `challenge` += 1, wrapping modulo `2^SEL_W`.
- If `bit_count` becomes KEY_BITS, `key_valid <= 1`.
- If `key_valid==1`: `key`, `bit_count`, `challenge` and `tie_seen` are unchanged.
- In both cases, both counters clear to 0 in the same cycle. Clear has priority over any increment that cycle.

Restart on `restart==1`:
- Clears counters, `key`, `bit_count`, `challenge`, `key_valid` and `tie_seen` next edge.
- Has priority over `done` and over counting in the same cycle.

Other rules:
- `done` while `start_count==0` still captures, using the held counts.
- Synchroniser flops are not cleared by `restart`; only `rst` clears them.

## Timing
- Reset (`rst` high, async): all outputs and all internal registers read 0 immediately.
  - This includes `key`, `bit_count`, `challenge`, `key_valid`, `tie_seen`, the counters and the sync flops.
- RO edge to counter increment: 3 `clk` cycles (2 sync + 1 edge stage).
  - Edges in the last 3 cycles before `start_count` falls are not counted.
  - Because `start_count` gates at the counter, edges already in the pipe when it rises are counted.
- Valid RO frequency: < `f_clk/2`. Faster oscillators alias; this is out of scope and not flagged.
- `done` at edge N:
  - `key`, `bit_count` and `challenge` update and counters read 0 after edge N.
  - `key_valid` is high after the edge capturing bit KEY_BITS.
- Reset mid-measurement: everything returns to 0 and no partial bit is kept.
- No backpressure; one capture per `done` pulse.

## Test plan
- **Basic capture:** `rst`, then `start_count` high for 200 clks with `ro_a` period 8 clks and `ro_b` period 10 clks, then `done` → `key[0]=1`, `bit_count=1`, `challenge=1`, counters 0.
- **Full key:** KEY_BITS=4, run 4 measurements with A faster, B faster, equal, A faster.
  - Required: `key=4'b1001`, `key_valid=1`, `tie_seen=1`.
  - A 5th `done` leaves `key`, `bit_count=4` and `challenge=0` unchanged.
- **Saturation:** CNT_W=4, 40 A edges and 5 B edges → `cnt_a=15`, bit 1; no wrap to a small value.
- **Priority:**
  - `restart` and `done` in the same cycle → all state 0, no bit captured.
  - An edge detect coinciding with `done` → counter reads 0 afterwards.
- **Gating:** toggle `ro_a` with `start_count=0` for 100 clks → `cnt_a` stays 0. Then a `done` captures bit 0 and sets `tie_seen`.
- **Async reset mid-window:** assert `rst` between clock edges at count 50 → all outputs 0 before the next `clk` edge.
